// File: rtl/sseg_scan_sched_if.sv
// sseg_scan_sched_if: control, update handshake and display bus of the seven-segment scan scheduler
interface sseg_scan_sched_if;
   logic        enable;
   logic        upd_req;
   logic [15:0] upd_data;
   logic        upd_ack;
   logic [3:0]  dig_en;
   logic [3:0]  disp_select;
   logic [7:0]  seven_value;
   logic        frame_done;
   modport master (
      output enable, upd_req, upd_data, dig_en,
      input  upd_ack, disp_select, seven_value, frame_done
   );
   modport slave (
      input  enable, upd_req, upd_data, dig_en,
      output upd_ack, disp_select, seven_value, frame_done
   );
endinterface

// File: rtl/sseg_scan_sched.sv
// sseg_scan_sched: 4-digit multiplexed seven-segment scanner with blanking dead-time and frame-aligned double buffering (SSEG_LZB_EN enables leading-zero blanking)
module sseg_scan_sched #(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic               clk,
   input logic               reset,
   sseg_scan_sched_if.slave  bus
);
   localparam int CW = $clog2(DIGIT_CYCLES);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BLANK = 2'd1;
   localparam logic [1:0] DRIVE = 2'd2;
   localparam logic [1:0] FIRST = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
   localparam logic [CW-1:0] DC_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BC_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [15:0]   shadow_q, shadow_d;
   logic          ack_q, ack_d;
   logic          fd_q, fd_d;
   logic [3:0]    sel_q, sel_d;
   logic [7:0]    seg_q, seg_d;
   logic          take, lzb, lit;

   function automatic logic [7:0] seg_pat(input logic [3:0] n);
      case (n)
         4'h0: seg_pat = 8'hFC;
         4'h1: seg_pat = 8'h60;
         4'h2: seg_pat = 8'hDA;
         4'h3: seg_pat = 8'hF2;
         4'h4: seg_pat = 8'h66;
         4'h5: seg_pat = 8'hB6;
         4'h6: seg_pat = 8'hBE;
         4'h7: seg_pat = 8'hE0;
         4'h8: seg_pat = 8'hFE;
         4'h9: seg_pat = 8'hF6;
         4'hA: seg_pat = 8'hEE;
         4'hB: seg_pat = 8'h3E;
         4'hC: seg_pat = 8'h9C;
         4'hD: seg_pat = 8'h7A;
         4'hE: seg_pat = 8'h9E;
         default: seg_pat = 8'h8E;
      endcase
   endfunction

   // Slot sequencing: the counter runs across the blank and drive phases of one digit slot
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      digit_d = digit_q;
      if (!bus.enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         digit_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FIRST;
               cnt_d   = '0;
               digit_d = '0;
            end
            BLANK: begin
               cnt_d   = cnt_q + CW'(1);
               state_d = (cnt_q == BC_LAST) ? DRIVE : BLANK;
            end
            DRIVE: begin
               cnt_d   = (cnt_q == DC_LAST) ? '0 : cnt_q + CW'(1);
               digit_d = (cnt_q == DC_LAST) ? digit_q + 2'd1 : digit_q;
               state_d = (cnt_q == DC_LAST) ? FIRST : DRIVE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output decode and shadow commit; new values land only at frame end or while idle
   always_comb begin
      fd_d     = (state_q != IDLE) && (digit_q == 2'd3) && (cnt_q == DC_LAST);
      take     = bus.upd_req && !ack_q && ((state_q == IDLE) || fd_d);
      ack_d    = take;
      shadow_d = take ? bus.upd_data : shadow_q;
`ifdef SSEG_LZB_EN
      lzb      = (digit_q != 2'd0) && ((shadow_q >> {digit_q, 2'b00}) == 16'h0);
`else
      lzb      = 1'b0;
`endif
      lit      = bus.enable && (state_q == DRIVE) && bus.dig_en[digit_q] && !lzb;
      sel_d    = lit ? ~(4'b0001 << digit_q) : 4'hF;
      seg_d    = lit ? ~seg_pat(shadow_q[{digit_q, 2'b00} +: 4]) : 8'hFF;
   end

   // State and registered outputs; reset leaves the display dark and drops any pending handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         digit_q  <= '0;
         shadow_q <= 16'h0000;
         ack_q    <= 1'b0;
         fd_q     <= 1'b0;
         sel_q    <= 4'hF;
         seg_q    <= 8'hFF;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         digit_q  <= digit_d;
         shadow_q <= shadow_d;
         ack_q    <= ack_d;
         fd_q     <= fd_d;
         sel_q    <= sel_d;
         seg_q    <= seg_d;
      end
   end

   assign bus.upd_ack     = ack_q;
   assign bus.frame_done  = fd_q;
   assign bus.disp_select = sel_q;
   assign bus.seven_value = seg_q;
endmodule
